// File: rtl/otg_hpi_pkg.sv
// Shared definitions for the CY7C67200 HPI bus master.
//   hpi_state_e  : sequencer states
//   HPI_*        : HPI register offsets as seen on avs_address / hpi_addr
//   CNT_W        : width of the shared phase down-counter
package otg_hpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } hpi_state_e;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int CNT_W = 4;

endpackage

// File: rtl/otg_hpi_bus_master_sync.sv
// Two-flop synchroniser for the asynchronous HPI interrupt line.
//   clk   : system clock
//   reset : synchronous, active-high reset (both flops cleared)
//   d     : asynchronous input
//   q     : synchronised output, two clk edges behind d
module otg_hpi_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/otg_hpi_bus_master.sv
// Avalon-MM slave that turns single reads/writes into timed CY7C67200 HPI
// cycles (setup, strobe, hold, recovery) and synchronises the chip interrupt.
//   clk, reset                       : system clock, synchronous active-high reset
//   avs_address/read/write/writedata : Avalon request (held until ack)
//   avs_readdata, avs_waitrequest    : Avalon response; ack is one cycle of waitrequest=0
//   hpi_addr, hpi_cs_n/rd_n/wr_n     : HPI pins
//   hpi_data_out/oe, hpi_data_in     : split data bus, pad built one level up
//   hpi_int -> irq                   : interrupt, two-flop synchronised
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for avs_read/avs_write; cs_n high
// ST_SETUP   | cs_n low, address (and write data) valid, strobes high
// ST_STROBE  | rd_n or wr_n low; read data captured on the last cycle
// ST_HOLD    | strobes high, cs_n/address/data held; ack on the last cycle
// ST_RECOVER | cs_n high for the chip's recovery time; requests stalled
module otg_hpi_bus_master
    import otg_hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    input  logic        hpi_int,
    output logic        irq
);

    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_STROBE  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RECOVER = CNT_W'(RECOVER_CYC - 1);

    hpi_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_wr_q, is_wr_d;
    logic [1:0]       addr_d;
    logic [15:0]      wdata_d;
    logic             cs_n_d, rd_n_d, wr_n_d, oe_d, wait_d;
    logic [15:0]      rdata_d;
    logic             last;

    assign last = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            is_wr_q         <= 1'b0;
            hpi_addr        <= '0;
            hpi_data_out    <= '0;
            hpi_cs_n        <= 1'b1;
            hpi_rd_n        <= 1'b1;
            hpi_wr_n        <= 1'b1;
            hpi_data_oe     <= 1'b0;
            avs_waitrequest <= 1'b1;
            avs_readdata    <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            is_wr_q         <= is_wr_d;
            hpi_addr        <= addr_d;
            hpi_data_out    <= wdata_d;
            hpi_cs_n        <= cs_n_d;
            hpi_rd_n        <= rd_n_d;
            hpi_wr_n        <= wr_n_d;
            hpi_data_oe     <= oe_d;
            avs_waitrequest <= wait_d;
            avs_readdata    <= rdata_d;
        end
    end

    // Next state, phase counter and latched request fields.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = hpi_addr;
        wdata_d = hpi_data_out;
        case (state_q)
            ST_IDLE: begin
                if (avs_read || avs_write) begin
                    state_d = ST_SETUP;
                    cnt_d   = LD_SETUP;
                    is_wr_d = avs_write;    // write wins over a simultaneous read
                    addr_d  = avs_address;
                    wdata_d = avs_writedata;
                end
            end
            ST_SETUP: begin
                if (last) begin
                    state_d = ST_STROBE;
                    cnt_d   = LD_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (last) begin
                    state_d = ST_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (last) begin
                    state_d = ST_RECOVER;
                    cnt_d   = LD_RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RECOVER: begin
                if (last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the *next* state so that every pin comes
    // straight off a flop yet still lines up with the state it belongs to.
    always_comb begin
        cs_n_d  = !(state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
        rd_n_d  = !(state_d == ST_STROBE && !is_wr_d);
        wr_n_d  = !(state_d == ST_STROBE && is_wr_d);
        oe_d    = !cs_n_d && is_wr_d;
        wait_d  = !(state_d == ST_HOLD && cnt_d == '0);
        rdata_d = avs_readdata;
        if (state_q == ST_STROBE && last && !is_wr_q) begin
            rdata_d = hpi_data_in;
        end
    end

    otg_hpi_sync2 u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (hpi_int),
        .q     (irq)
    );

endmodule

// File: tb/tb_otg_hpi_bus_master.sv
module tb_otg_hpi_bus_master;
    import otg_hpi_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_read, avs_write;
    logic [15:0] avs_writedata, avs_readdata;
    logic        avs_waitrequest;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_data_out, hpi_data_in;
    logic        hpi_data_oe, hpi_cs_n, hpi_rd_n, hpi_wr_n;
    logic        hpi_int, irq;
    logic [15:0] chip_val;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    // Chip model: drives its data only while the read strobe is low.
    assign hpi_data_in = hpi_rd_n ? 16'h0000 : chip_val;

    otg_hpi_bus_master dut (
        .clk             (clk),
        .reset           (reset),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .hpi_addr        (hpi_addr),
        .hpi_data_out    (hpi_data_out),
        .hpi_data_oe     (hpi_data_oe),
        .hpi_data_in     (hpi_data_in),
        .hpi_cs_n        (hpi_cs_n),
        .hpi_rd_n        (hpi_rd_n),
        .hpi_wr_n        (hpi_wr_n),
        .hpi_int         (hpi_int),
        .irq             (irq)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is in cycle 0 (DUT idle). Checks cycles 1..11 against default timing:
    // SETUP 1, STROBE 2-5, HOLD/ack 6, RECOVER 7-10, IDLE 11.
    task automatic run_txn(input string nm, input logic wr, input logic rd,
                           input logic [1:0] a, input logic [15:0] d,
                           input logic [15:0] exp_rd);
        avs_write     = wr;
        avs_read      = rd;
        avs_address   = a;
        avs_writedata = d;
        for (int k = 1; k <= 11; k++) begin
            logic act, stb;
            tick();
            act = (k <= 6);
            stb = (k >= 2 && k <= 5);
            chk($sformatf("%s c%0d cs_n", nm, k), 16'(hpi_cs_n), 16'(!act));
            chk($sformatf("%s c%0d wr_n", nm, k), 16'(hpi_wr_n), 16'(!(stb && wr)));
            chk($sformatf("%s c%0d rd_n", nm, k), 16'(hpi_rd_n), 16'(!(stb && !wr)));
            chk($sformatf("%s c%0d oe", nm, k), 16'(hpi_data_oe), 16'(act && wr));
            chk($sformatf("%s c%0d wait", nm, k), 16'(avs_waitrequest), 16'(k != 6));
            if (act) chk($sformatf("%s c%0d addr", nm, k), 16'(hpi_addr), 16'(a));
            if (act && wr) chk($sformatf("%s c%0d dout", nm, k), hpi_data_out, d);
            if (k == 6) begin
                chk($sformatf("%s rdata", nm), avs_readdata, exp_rd);
                avs_write = 1'b0;
                avs_read  = 1'b0;
            end
        end
    endtask

    initial begin
        int fall1, fall2, high_run, ack2;
        logic prev_cs;

        reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; hpi_int = 1'b0; chip_val = 16'h0000;
        repeat (3) tick();
        chk("rst cs_n", 16'(hpi_cs_n), 16'd1);
        chk("rst rd_n", 16'(hpi_rd_n), 16'd1);
        chk("rst wr_n", 16'(hpi_wr_n), 16'd1);
        chk("rst oe", 16'(hpi_data_oe), 16'd0);
        chk("rst addr", 16'(hpi_addr), 16'd0);
        chk("rst dout", hpi_data_out, 16'h0000);
        chk("rst rdata", avs_readdata, 16'h0000);
        chk("rst wait", 16'(avs_waitrequest), 16'd1);
        chk("rst irq", 16'(irq), 16'd0);
        reset = 1'b0;
        tick();

        run_txn("wr_addr", 1'b1, 1'b0, HPI_ADDRESS, 16'h1000, 16'h0000);

        chip_val = 16'hBEEF;
        run_txn("rd_data", 1'b0, 1'b1, HPI_DATA, 16'h0000, 16'hBEEF);

        chip_val = 16'h7777;
        run_txn("rw_both", 1'b1, 1'b1, HPI_MAILBOX, 16'h00A5, 16'hBEEF);

        // Back-to-back: write held until ack, then read held until its ack.
        chip_val = 16'hCAFE;
        avs_write = 1'b1; avs_address = HPI_STATUS; avs_writedata = 16'h5A5A;
        fall1 = -1; fall2 = -1; high_run = 0; ack2 = -1; prev_cs = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (prev_cs && !hpi_cs_n) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (fall1 >= 0 && fall2 < 0 && hpi_cs_n) high_run++;
            prev_cs = hpi_cs_n;
            if (k == 6) begin
                chk("b2b wr ack", 16'(avs_waitrequest), 16'd0);
                avs_write = 1'b0; avs_read = 1'b1; avs_address = HPI_DATA;
            end else if (k > 6 && !avs_waitrequest && ack2 < 0) begin
                ack2 = k;
                chk("b2b rdata", avs_readdata, 16'hCAFE);
                avs_read = 1'b0;
            end
        end
        chk("b2b fall1", 16'(fall1), 16'd1);
        chk("b2b period", 16'(fall2 - fall1), 16'd11);
        chk("b2b cs high>=4", 16'(high_run >= 4), 16'd1);
        chk("b2b ack2", 16'(ack2), 16'd17);

        // Reset in cycle 3 of a write.
        avs_write = 1'b1; avs_address = HPI_MAILBOX; avs_writedata = 16'h1234;
        repeat (3) tick();
        chk("mid c3 wr_n", 16'(hpi_wr_n), 16'd0);
        reset = 1'b1; avs_write = 1'b0;
        tick();
        chk("mid wr_n", 16'(hpi_wr_n), 16'd1);
        chk("mid cs_n", 16'(hpi_cs_n), 16'd1);
        chk("mid oe", 16'(hpi_data_oe), 16'd0);
        chk("mid wait", 16'(avs_waitrequest), 16'd1);
        chk("mid rdata", avs_readdata, 16'h0000);
        reset = 1'b0;
        begin
            int acks = 0;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (!avs_waitrequest || !hpi_cs_n) acks++;
            end
            chk("mid no ack", 16'(acks), 16'd0);
        end
        chip_val = 16'h1234;
        run_txn("rd_after", 1'b0, 1'b1, HPI_STATUS, 16'h0000, 16'h1234);

        // Interrupt: 3-cycle pulse appears on irq two edges later.
        hpi_int = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("irq c%0d", k), 16'(irq), 16'(k >= 2 && k <= 4));
            if (k == 3) hpi_int = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
